maxpool_22: RTL and testbench



---
 rtl/maxpool_22.sv | 87 ++++++++
 tb/tb_maxpool_22.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_22.sv
// 2x2 stride-2 signed max-pool over a raster D x D stream, one half-width line buffer.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero in the output register.
module maxpool_22 #(
  parameter int D          = 220,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int H  = D / 2;
  localparam int CW = (D > 2) ? $clog2(D) : 1;
  localparam int KW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  if (D < 2 || (D % 2) != 0) begin : g_bad_d
    $error("maxpool_22: D must be even and at least 2");
  end

  logic [CW-1:0]         col;
  logic [CW-1:0]         row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] lbuf [H];
  logic [KW-1:0]         k;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] win_max;

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] out_map(input logic [DATA_WIDTH-1:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[DATA_WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  assign k        = KW'(col >> 1);
  assign pair_max = smax(hold, pxl_in);
  assign win_max  = smax(lbuf[k], pair_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          hold <= pxl_in;
        end else if (row[0]) begin
          // Bottom-right pixel of a window: fold in the stored top-row maximum.
          pxl_out    <= out_map(win_max);
          valid_out  <= 1'b1;
          frame_done <= (row == LAST) && (col == LAST);
        end
      end
    end
  end

  // Top-row pair maxima; every entry is rewritten on each even row before use.
  always_ff @(posedge clk) begin
    if (!reset && valid_in && col[0] && !row[0]) begin
      lbuf[k] <= pair_max;
    end
  end

endmodule

// File: tb/tb_maxpool_22.sv
// Scoreboard bench for maxpool_22: a D=4 instance for directed streams and a D=220 instance
// for a random frame checked against a software 2x2 max-pool.
module tb_maxpool_22;

  localparam int DB = 220;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       v4 = 1'b0;
  logic [7:0] p4 = '0;
  logic [7:0] o4;
  logic       vo4, fd4;
  logic       vb = 1'b0;
  logic [7:0] pb = '0;
  logic [7:0] ob;
  logic       vob, fdb;

  maxpool_22 #(.D(4), .DATA_WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .valid_in(v4), .pxl_in(p4),
    .pxl_out(o4), .valid_out(vo4), .frame_done(fd4)
  );

  maxpool_22 #(.D(DB), .DATA_WIDTH(8)) dutb (
    .clk(clk), .reset(reset), .valid_in(vb), .pxl_in(pb),
    .pxl_out(ob), .valid_out(vob), .frame_done(fdb)
  );

  typedef struct {
    logic [7:0] val;
    logic       last;
    int         at;
  } exp_t;

  exp_t q4[$];
  exp_t qb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pulses4 = 0, done4 = 0, pulsesb = 0, doneb = 0;

  logic [7:0] frame4 [16];
  byte        exp4 [4];
  byte        big [DB*DB];

  always @(posedge clk) cyc <= cyc + 1;

  exp_t e4;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (vo4 === 1'b1) begin
        pulses4++;
        checks++;
        if (q4.size() == 0) begin
          failures++;
          $display("FAIL d4_unexpected_pulse got=%0d cyc=%0d", $signed(o4), cyc);
        end else begin
          e4 = q4.pop_front();
          if (o4 !== e4.val || fd4 !== e4.last || cyc !== e4.at) begin
            failures++;
            $display("FAIL d4_output got=%0d/done=%b/cyc=%0d want=%0d/done=%b/cyc=%0d",
                     $signed(o4), fd4, cyc, $signed(e4.val), e4.last, e4.at);
          end
        end
      end else if (fd4 !== 1'b0 || vo4 !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL d4_idle got valid=%b done=%b want 0/0", vo4, fd4);
      end
      if (fd4 === 1'b1) done4++;
    end
  end

  exp_t eb;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (vob === 1'b1) begin
        pulsesb++;
        checks++;
        if (qb.size() == 0) begin
          failures++;
          $display("FAIL d220_unexpected_pulse got=%0d cyc=%0d", $signed(ob), cyc);
        end else begin
          eb = qb.pop_front();
          if (ob !== eb.val || fdb !== eb.last || cyc !== eb.at) begin
            failures++;
            $display("FAIL d220_output got=%0d/done=%b/cyc=%0d want=%0d/done=%b/cyc=%0d",
                     $signed(ob), fdb, cyc, $signed(eb.val), eb.last, eb.at);
          end
        end
      end else if (fdb !== 1'b0 || vob !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL d220_idle got valid=%b done=%b want 0/0", vob, fdb);
      end
      if (fdb === 1'b1) doneb++;
    end
  end

  task automatic idle4(input int n);
    repeat (n) begin
      @(negedge clk);
      v4 = 1'b0;
    end
  endtask

  // Windows of a 4x4 frame complete at raster indices 5, 7, 13, 15.
  task automatic drive_frame4(input int max_gap);
    exp_t e;
    int   j = 0;
    int   n;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v4 = 1'b1;
      p4 = frame4[i];
      if (((i >> 2) & 1) == 1 && (i & 1) == 1) begin
        e.val  = exp4[j];
        e.last = (i == 15);
        e.at   = cyc + 1;
        q4.push_back(e);
        j++;
      end
      if (max_gap > 0) begin
        n = $urandom_range(1, max_gap);
        repeat (n) begin
          @(negedge clk);
          v4 = 1'b0;
        end
      end
    end
  endtask

  task automatic set_ramp_up();
    for (int i = 0; i < 16; i++) frame4[i] = 8'(i);
    exp4[0] = 5; exp4[1] = 7; exp4[2] = 13; exp4[3] = 15;
  endtask

  task automatic check_end4(input string name, input int p0, input int d0,
                            input int np, input int nd);
    checks++;
    if (pulses4 - p0 !== np || done4 - d0 !== nd || q4.size() != 0) begin
      failures++;
      $display("FAIL %s_counts got pulses=%0d done=%0d pending=%0d want %0d/%0d/0",
               name, pulses4 - p0, done4 - d0, q4.size(), np, nd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o4 !== 8'd0 || vo4 !== 1'b0 || fd4 !== 1'b0 ||
        ob !== 8'd0 || vob !== 1'b0 || fdb !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got d4=%0d/%b/%b d220=%0d/%b/%b want 0/0/0",
               o4, vo4, fd4, ob, vob, fdb);
    end
    reset = 1'b0;
  endtask

  task automatic test_raster();
    int p0 = pulses4, d0 = done4;
    set_ramp_up();
    drive_frame4(0);
    idle4(4);
    check_end4("raster", p0, d0, 4, 1);
    checks++;
    if (o4 !== 8'd15) begin
      failures++;
      $display("FAIL raster_hold got=%0d want=15", o4);
    end
  endtask

  task automatic test_negative();
    int p0 = pulses4, d0 = done4;
    for (int i = 0; i < 16; i++) frame4[i] = 8'(i - 16);
`ifdef MAXPOOL_RELU_EN
    exp4[0] = 0; exp4[1] = 0; exp4[2] = 0; exp4[3] = 0;
`else
    exp4[0] = -11; exp4[1] = -9; exp4[2] = -3; exp4[3] = -1;
`endif
    drive_frame4(0);
    idle4(3);
    check_end4("negative", p0, d0, 4, 1);
  endtask

  task automatic test_gaps();
    int p0 = pulses4, d0 = done4;
    set_ramp_up();
    drive_frame4(3);
    idle4(3);
    check_end4("gaps", p0, d0, 4, 1);
  endtask

  task automatic test_mid_reset();
    int p0 = pulses4, d0 = done4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v4 = 1'b1;
      p4 = 8'(i);
    end
    // Sixth pixel coincides with reset and must be ignored.
    @(negedge clk);
    reset = 1'b1;
    v4 = 1'b1;
    p4 = 8'd5;
    @(negedge clk);
    reset = 1'b0;
    v4 = 1'b0;
    idle4(2);
    check_end4("mid_reset_quiet", p0, d0, 0, 0);
    set_ramp_up();
    drive_frame4(0);
    idle4(3);
    check_end4("mid_reset_frame", p0, d0, 4, 1);
  endtask

  task automatic test_back_to_back();
    int p0 = pulses4, d0 = done4;
    set_ramp_up();
    drive_frame4(0);
    for (int i = 0; i < 16; i++) frame4[i] = 8'(15 - i);
    exp4[0] = 15; exp4[1] = 13; exp4[2] = 7; exp4[3] = 5;
    drive_frame4(0);
    idle4(3);
    check_end4("back_to_back", p0, d0, 8, 2);
  endtask

  function automatic logic [7:0] pool_model(input int r, input int c);
    byte m;
    m = big[(r - 1) * DB + c - 1];
    if (big[(r - 1) * DB + c] > m) m = big[(r - 1) * DB + c];
    if (big[r * DB + c - 1] > m) m = big[r * DB + c - 1];
    if (big[r * DB + c] > m) m = big[r * DB + c];
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  task automatic test_full_frame();
    exp_t e;
    int   p0 = pulsesb, d0 = doneb;
    for (int i = 0; i < DB * DB; i++) big[i] = byte'($urandom_range(0, 255));
    for (int r = 0; r < DB; r++) begin
      for (int c = 0; c < DB; c++) begin
        @(negedge clk);
        vb = 1'b1;
        pb = big[r * DB + c];
        if ((r & 1) == 1 && (c & 1) == 1) begin
          e.val  = pool_model(r, c);
          e.last = (r == DB - 1) && (c == DB - 1);
          e.at   = cyc + 1;
          qb.push_back(e);
        end
      end
    end
    @(negedge clk);
    vb = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pulsesb - p0 !== 12100 || doneb - d0 !== 1 || qb.size() != 0) begin
      failures++;
      $display("FAIL full_frame_counts got pulses=%0d done=%0d pending=%0d want 12100/1/0",
               pulsesb - p0, doneb - d0, qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_negative();
    test_gaps();
    test_mid_reset();
    test_back_to_back();
    test_full_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
